// File: rtl/forward_ctrl.sv
// forward_ctrl
//   Operand-forwarding and load-use hazard control for the EXE-stage operand
//   multiplexers. Keeps a shadow E/M/W pipeline of destination tags and,
//   when FORWARD_EN is defined, produces registered per-operand selects
//   (00 = register file, 01 = MEM-stage ALU result, 10 = WB value).
//   Without FORWARD_EN the pipeline is stall-only: selects are tied to 00 and
//   any RAW match against E or M stalls IF/ID.
//
// Configuration macro: FORWARD_EN (undefined = stall-only pipeline)
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   freeze          global hold, all state kept
//   flush           squash the instruction in ID (turns into a bubble)
//   id_src1/src2    ID source registers, id_use_src2 qualifies src2
//   id_dest, id_wb_en, id_mem_read   ID destination info
//   sel_a, sel_b    operand mux selects, valid during the EXE cycle
//   hazard          combinational stall request towards IF/ID
//   stall_cnt       saturating count of stalled (non-frozen) cycles
module forward_ctrl #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_W-1:0] e_dest_q, e_dest_d, m_dest_q, m_dest_d, w_dest_q, w_dest_d;
  logic             e_wb_q, e_wb_d, m_wb_q, m_wb_d, w_wb_q, w_wb_d;
  logic             e_mr_q, e_mr_d, m_mr_q, m_mr_d, w_mr_q, w_mr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hit_e1, hit_e2, hit_m1, hit_m2;
  logic hazard_c;
  logic bubble;

  // RAW matches of the ID sources against the in-flight producers.
  always_comb begin
    hit_e1 = e_wb_q && (e_dest_q == id_src1);
    hit_e2 = id_use_src2 && e_wb_q && (e_dest_q == id_src2);
    hit_m1 = m_wb_q && (m_dest_q == id_src1);
    hit_m2 = id_use_src2 && m_wb_q && (m_dest_q == id_src2);
`ifdef FORWARD_EN
    // Only a load in E cannot be bypassed; one bubble moves it to M where
    // the WB-value path covers the consumer.
    hazard_c = !flush && e_mr_q && (hit_e1 || hit_e2);
`else
    hazard_c = !flush && (hit_e1 || hit_e2 || hit_m1 || hit_m2);
`endif
    bubble = flush || hazard_c;
  end

  assign hazard    = hazard_c;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    e_dest_d = e_dest_q;
    e_wb_d   = e_wb_q;
    e_mr_d   = e_mr_q;
    m_dest_d = m_dest_q;
    m_wb_d   = m_wb_q;
    m_mr_d   = m_mr_q;
    w_dest_d = w_dest_q;
    w_wb_d   = w_wb_q;
    w_mr_d   = w_mr_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      w_dest_d = m_dest_q;
      w_wb_d   = m_wb_q;
      w_mr_d   = m_mr_q;
      m_dest_d = e_dest_q;
      m_wb_d   = e_wb_q;
      m_mr_d   = e_mr_q;
      if (bubble) begin
        e_dest_d = '0;
        e_wb_d   = 1'b0;
        e_mr_d   = 1'b0;
      end else begin
        e_dest_d = id_dest;
        e_wb_d   = id_wb_en;
        e_mr_d   = id_mem_read;
      end
      if (hazard_c && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_dest_q    <= '0;
      e_wb_q      <= 1'b0;
      e_mr_q      <= 1'b0;
      m_dest_q    <= '0;
      m_wb_q      <= 1'b0;
      m_mr_q      <= 1'b0;
      w_dest_q    <= '0;
      w_wb_q      <= 1'b0;
      w_mr_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      e_dest_q    <= e_dest_d;
      e_wb_q      <= e_wb_d;
      e_mr_q      <= e_mr_d;
      m_dest_q    <= m_dest_d;
      m_wb_q      <= m_wb_d;
      m_mr_q      <= m_mr_d;
      w_dest_q    <= w_dest_d;
      w_wb_q      <= w_wb_d;
      w_mr_q      <= w_mr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef FORWARD_EN
  logic [1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;

  // Selects are computed against the state seen by the ID instruction and
  // registered alongside it into E; E is checked first so the youngest
  // producer wins.
  always_comb begin
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!freeze) begin
      sel_a_d = SEL_RF;
      sel_b_d = SEL_RF;
      if (!bubble) begin
        if (hit_e1)      sel_a_d = SEL_MEM;
        else if (hit_m1) sel_a_d = SEL_WB;
        if (hit_e2)      sel_b_d = SEL_MEM;
        else if (hit_m2) sel_b_d = SEL_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;
`else
  assign sel_a = SEL_RF;
  assign sel_b = SEL_RF;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl
//   Directed test of forward_ctrl in whichever mode is built (FORWARD_EN
//   defined or not). A second instance with a 2-bit counter exercises
//   stall_cnt saturation.
module tb_forward_ctrl;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       freeze;
  logic       flush;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       id_use_src2, id_wb_en, id_mem_read;
  logic [1:0] sel_a, sel_b;
  logic       hazard;
  logic [15:0] stall_cnt;
  logic [1:0] s_sel_a, s_sel_b;
  logic       s_hazard;
  logic [1:0] s_stall_cnt;

  int unsigned n_checks;
  int unsigned n_pass;

  forward_ctrl #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .sel_a(sel_a), .sel_b(sel_b), .hazard(hazard), .stall_cnt(stall_cnt)
  );

  forward_ctrl #(.REG_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .sel_a(s_sel_a), .sel_b(s_sel_b), .hazard(s_hazard), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic u2,
                       input logic [3:0] d, input logic wb, input logic mr);
    id_src1 = s1;
    id_src2 = s2;
    id_use_src2 = u2;
    id_dest = d;
    id_wb_en = wb;
    id_mem_read = mr;
    #1;
  endtask

  // ID instruction held while hazard is expected for n cycles, then clear.
  task automatic expect_stalls(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check(tag, 32'(hazard), 1);
      tick();
    end
    check({tag, "_clear"}, 32'(hazard), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b0;
    freeze = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      freeze = 1'($urandom);
      flush = 1'($urandom);
      drive(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("rst_sel_a", 32'(sel_a), 0);
    check("rst_sel_b", 32'(sel_b), 0);
    check("rst_hazard", 32'(hazard), 0);
    check("rst_cnt", 32'(stall_cnt), 0);
    check("rst_sat_cnt", 32'(s_stall_cnt), 0);
    tick();
    check("idle_hazard", 32'(hazard), 0);

    // ALU back-to-back: ADD r3, SUB r6 <- r3,r5, then r7 <- r3
    drive(1, 2, 1, 3, 1, 0);
    check("add_hz", 32'(hazard), 0);
    tick();
    drive(3, 5, 1, 6, 1, 0);
    expect_stalls("sub_hz", FWD ? 0 : 2);
    tick();
    check("sub_sel_a", 32'(sel_a), FWD ? 1 : 0);
    check("sub_sel_b", 32'(sel_b), 0);
    drive(3, 0, 0, 7, 1, 0);
    check("third_hz", 32'(hazard), 0);
    tick();
    check("third_sel_a", 32'(sel_a), FWD ? 2 : 0);
    check("third_sel_b", 32'(sel_b), 0);
    check("alu_cnt", 32'(stall_cnt), FWD ? 0 : 2);

    // Priority: two writers of r4, reader on src2
    drive(8, 9, 1, 4, 1, 0);
    check("pri_i1_hz", 32'(hazard), 0);
    tick();
    drive(10, 11, 1, 4, 1, 0);
    check("pri_i2_hz", 32'(hazard), 0);
    tick();
    drive(12, 4, 1, 5, 1, 0);
    expect_stalls("pri_hz", FWD ? 0 : 2);
    tick();
    check("pri_sel_a", 32'(sel_a), 0);
    check("pri_sel_b", 32'(sel_b), FWD ? 1 : 0);

    // Load-use: LDR r2, then ADD r8 <- r2, r14
    drive(13, 0, 0, 2, 1, 1);
    check("ldr_hz", 32'(hazard), 0);
    tick();
    drive(2, 14, 1, 8, 1, 0);
    expect_stalls("ldu_hz", FWD ? 1 : 2);
    check("ldu_bubble_sel_a", 32'(sel_a), 0);
    check("ldu_cnt_stall", 32'(stall_cnt), FWD ? 1 : 6);
    tick();
    check("ldu_sel_a", 32'(sel_a), FWD ? 2 : 0);
    check("ldu_sel_b", 32'(sel_b), 0);
    check("ldu_cnt", 32'(stall_cnt), FWD ? 1 : 6);

    // Flush with a load-use pair pending
    drive(1, 0, 0, 9, 1, 1);
    check("ldr2_hz", 32'(hazard), 0);
    tick();
    flush = 1'b1;
    drive(9, 0, 0, 10, 1, 0);
    check("flush_hz", 32'(hazard), 0);
    tick();
    flush = 1'b0;
    check("flush_sel_a", 32'(sel_a), 0);
    drive(10, 0, 0, 11, 1, 0);
    check("post_flush_hz", 32'(hazard), 0);
    tick();
    check("post_flush_sel_a", 32'(sel_a), 0);
    check("flush_cnt", 32'(stall_cnt), FWD ? 1 : 6);

    // Freeze for 3 cycles with a dependent instruction in ID
    freeze = 1'b1;
    drive(11, 0, 0, 12, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check("frz_hz", 32'(hazard), FWD ? 0 : 1);
      tick();
      check("frz_sel_a", 32'(sel_a), 0);
      check("frz_sel_b", 32'(sel_b), 0);
      check("frz_cnt", 32'(stall_cnt), FWD ? 1 : 6);
    end
    freeze = 1'b0;
    #1;
    expect_stalls("unfrz_hz", FWD ? 0 : 2);
    tick();
    check("unfrz_sel_a", 32'(sel_a), FWD ? 1 : 0);
    check("unfrz_cnt", 32'(stall_cnt), FWD ? 1 : 8);

    // Boundary registers r15 and r0
    drive(0, 0, 0, 15, 1, 0);
    check("r15_wr_hz", 32'(hazard), 0);
    tick();
    drive(15, 15, 1, 0, 1, 0);
    expect_stalls("r15_hz", FWD ? 0 : 2);
    tick();
    check("r15_sel_a", 32'(sel_a), FWD ? 1 : 0);
    check("r15_sel_b", 32'(sel_b), FWD ? 1 : 0);
    drive(0, 15, 1, 1, 1, 0);
    expect_stalls("r0_hz", FWD ? 0 : 2);
    tick();
    check("r0_sel_a", 32'(sel_a), FWD ? 1 : 0);
    check("r0_sel_b", 32'(sel_b), FWD ? 2 : 0);
    check("bound_cnt", 32'(stall_cnt), FWD ? 1 : 12);

    // Repeated load-use pairs push the 2-bit counter into saturation
    for (int i = 0; i < 4; i++) begin
      drive(14, 0, 0, 3, 1, 1);
      tick();
      drive(3, 0, 0, 0, 0, 0);
      check("rep_hz", 32'(hazard), 1);
      tick();
      tick();
      tick();
    end
    check("final_cnt", 32'(stall_cnt), FWD ? 5 : 20);
    check("sat_cnt", 32'(s_stall_cnt), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
